// File: rtl/bitrev_reorder_pkg.sv
// Shared definitions for the FFT input-reordering stage: read-FSM state
// encoding plus the clog2/bitrev constant helpers that the twiddle ROM and
// output stages also use.
package bitrev_reorder_pkg;

  // Read side is either waiting for a full bank or draining one.
  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  // Number of ping-pong banks backing the reorder buffer.
  localparam int NUM_BANKS = 2;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Reverse the 'bits' least-significant bits of idx; upper bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int bits);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < bits) begin
        r[bits-1-b] = idx[b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_reorder_dp_ram.sv
// Simple dual-port RAM for the reorder buffer: one write port and one read
// port whose data output is registered. Contents are never reset.
module bitrev_reorder_dp_ram #(
  parameter int word_size = 16,
  parameter int abits     = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [abits-1:0]     wr_addr,
  input  logic [word_size-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [abits-1:0]     rd_addr,
  output logic [word_size-1:0] rd_data
);

  localparam int depth = 1 << abits;

  logic [word_size-1:0] mem [depth];

  // Write port: store the incoming sample at its natural-order slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: registered output, holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bitrev_reorder.sv
// FFT input reordering: collects fft_length samples in natural order into one
// bank of a ping-pong buffer while the other bank is emitted in bit-reversed
// index order. Back-to-back frames stream with no gaps on the output.
module bitrev_reorder
  import bitrev_reorder_pkg::*;
#(
  parameter int word_size  = 16,
  parameter int fft_length = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [word_size-1:0] d_in,
  output logic [word_size-1:0] d_out,
  output logic                 d_valid,
  output logic                 frame_start,
  output logic [7:0]           frame_count
);

  localparam int addr_bits = clog2(fft_length);
  localparam int ram_abits = addr_bits + 1;
  localparam logic [addr_bits-1:0] last_idx = addr_bits'(fft_length - 1);

  // Bit-reversed read index within one bank.
  function automatic logic [addr_bits-1:0] rev_addr(input logic [addr_bits-1:0] i);
    return addr_bits'(bitrev(32'(i), addr_bits));
  endfunction

  // Write side state
  logic [addr_bits-1:0] wr_cnt;
  logic                 wr_bank;
  logic                 swap;

  // Read side state
  rd_state_t            rd_state;
  rd_state_t            rd_state_nxt;
  logic [addr_bits-1:0] rd_cnt;
  logic                 rd_bank;
  logic                 rd_active;
  logic                 rd_first;
  logic                 rd_last;

  // RAM ports
  logic [ram_abits-1:0] wr_addr;
  logic [ram_abits-1:0] rd_addr;
  logic [word_size-1:0] ram_q_p1;

  // Pipeline control
  logic                 vld_p1;
  logic                 first_p1;

  // ---------------- stage p0: write capture and read issue ----------------

  // Swap happens on the edge that writes the last sample of a frame.
  always_comb begin
    swap    = in_valid && (wr_cnt == last_idx);
    wr_addr = {wr_bank, wr_cnt};
  end

  // Write counter and bank select; holes in in_valid simply hold the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (in_valid) begin
      if (wr_cnt == last_idx) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt  <= wr_cnt + 1'b1;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  // Read FSM next state: a swap always (re)starts a drain, which lets a new
  // frame begin on the cycle right after the previous frame's last read.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: begin
        if (swap) begin
          rd_state_nxt = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (swap) begin
          rd_state_nxt = RD_DRAIN;
        end else if (rd_last) begin
          rd_state_nxt = RD_IDLE;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM outputs: read enable, frame-boundary flags and bank address.
  always_comb begin
    rd_active = (rd_state == RD_DRAIN);
    rd_first  = rd_active && (rd_cnt == '0);
    rd_last   = rd_active && (rd_cnt == last_idx);
    rd_addr   = {rd_bank, rev_addr(rd_cnt)};
  end

  // Read counter and bank: reload on swap, otherwise step through the drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (swap) begin
      rd_cnt  <= '0;
      rd_bank <= wr_bank;
    end else if (rd_active) begin
      rd_cnt  <= rd_cnt + 1'b1;
    end
  end

  bitrev_reorder_dp_ram #(
    .word_size (word_size),
    .abits     (ram_abits)
  ) u_ram (
    .clk     (clk),
    .wr_en   (in_valid),
    .wr_addr (wr_addr),
    .wr_data (d_in),
    .rd_en   (rd_active),
    .rd_addr (rd_addr),
    .rd_data (ram_q_p1)
  );

  // ---------------- stage p1: RAM data registered ----------------

  // Valid and first-sample flags travel alongside the RAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      vld_p1   <= rd_active;
      first_p1 <= rd_first;
    end
  end

  // ---------------- stage p2: output registers ----------------

  // Output register; d_out holds its last sample while nothing is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out       <= '0;
      d_valid     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      d_valid     <= vld_p1;
      frame_start <= vld_p1 && first_p1;
      if (vld_p1) begin
        d_out <= ram_q_p1;
      end
    end
  end

  // Emitted-frame counter, advancing once per frame_start and wrapping at 256.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= 8'd0;
    end else if (frame_start) begin
      frame_count <= frame_count + 8'd1;
    end
  end

endmodule
